// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter: shifts a captured word out MSB-first on Signal,
// optionally repeating it with an idle gap between copies.
module serial_pattern_tx #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned GAP_CYCLES = 2,
    parameter logic        IDLE_LEVEL = 1'b0
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Start,
    input  logic [WIDTH-1:0] Data,
    input  logic [3:0]       Repeat,
    input  logic             Abort,
    output logic             Ready,
    output logic             Busy,
    output logic             Signal,
    output logic             Done
);

    localparam int unsigned BW = $clog2(WIDTH);
    localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [BW-1:0] BitLast = BW'(WIDTH - 1);
    localparam logic [GW-1:0] GapLast = GW'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StShift, StGap} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [GW-1:0]    gap_cnt_q, gap_cnt_d;
    logic [3:0]       rep_q, rep_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             signal_q, signal_d;
    logic             done_q, done_d;

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        word_d    = word_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        rep_d     = rep_q;
        ready_d   = ready_q;
        busy_d    = busy_q;
        signal_d  = signal_q;
        done_d    = 1'b0;

        unique case (state_q)
            StIdle: begin
                ready_d  = 1'b1;
                busy_d   = 1'b0;
                signal_d = IDLE_LEVEL;
                if (Start) begin
                    state_d   = StShift;
                    shift_d   = Data;
                    word_d    = Data;
                    rep_d     = Repeat;
                    bit_cnt_d = '0;
                    ready_d   = 1'b0;
                    busy_d    = 1'b1;
                    signal_d  = Data[WIDTH-1];
                end
            end
            StShift: begin
                if (Abort) begin
                    state_d  = StIdle;
                    ready_d  = 1'b1;
                    busy_d   = 1'b0;
                    signal_d = IDLE_LEVEL;
                end else if (bit_cnt_q == BitLast) begin
                    if (rep_q != 4'd0) begin
                        rep_d = rep_q - 4'd1;
                        if (GAP_CYCLES > 0) begin
                            state_d   = StGap;
                            gap_cnt_d = '0;
                            signal_d  = IDLE_LEVEL;
                        end else begin
                            // Back-to-back copy: MSB follows LSB with no idle bit.
                            shift_d   = word_q;
                            bit_cnt_d = '0;
                            signal_d  = word_q[WIDTH-1];
                        end
                    end else begin
                        state_d  = StIdle;
                        done_d   = 1'b1;
                        ready_d  = 1'b1;
                        busy_d   = 1'b0;
                        signal_d = IDLE_LEVEL;
                    end
                end else begin
                    shift_d   = {shift_q[WIDTH-2:0], 1'b0};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    signal_d  = shift_q[WIDTH-2];
                end
            end
            StGap: begin
                if (Abort) begin
                    state_d  = StIdle;
                    ready_d  = 1'b1;
                    busy_d   = 1'b0;
                    signal_d = IDLE_LEVEL;
                end else if (gap_cnt_q == GapLast) begin
                    state_d   = StShift;
                    shift_d   = word_q;
                    bit_cnt_d = '0;
                    signal_d  = word_q[WIDTH-1];
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                    signal_d  = IDLE_LEVEL;
                end
            end
            default: begin
                state_d  = StIdle;
                ready_d  = 1'b1;
                busy_d   = 1'b0;
                signal_d = IDLE_LEVEL;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q   <= StIdle;
            shift_q   <= '0;
            word_q    <= '0;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
            rep_q     <= '0;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            signal_q  <= IDLE_LEVEL;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            word_q    <= word_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            rep_q     <= rep_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            signal_q  <= signal_d;
            done_q    <= done_d;
        end
    end

    assign Ready  = ready_q;
    assign Busy   = busy_q;
    assign Signal = signal_q;
    assign Done   = done_q;

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Scoreboard bench for serial_pattern_tx: one instance with a 2-cycle gap and one
// with back-to-back repeats, each with its own expected-output queue and monitor.
module tb_serial_pattern_tx;

    typedef struct packed {
        logic sig;
        logic done;
    } rec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, start_z, abort;
    logic [7:0] data;
    logic [3:0] rpt;
    logic       ready, busy, sig, done;
    logic       ready_z, busy_z, sig_z, done_z;

    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   push_n;
    rec_t exp_a[$];
    rec_t exp_z[$];
    int   dcyc_a[$];
    int   dcyc_z[$];
    rec_t rec_a, rec_z;

    serial_pattern_tx #(.WIDTH(8), .GAP_CYCLES(2), .IDLE_LEVEL(1'b0)) u_dut (
        .Clock (clk),
        .Reset (rst_n),
        .Start (start),
        .Data  (data),
        .Repeat(rpt),
        .Abort (abort),
        .Ready (ready),
        .Busy  (busy),
        .Signal(sig),
        .Done  (done)
    );

    serial_pattern_tx #(.WIDTH(8), .GAP_CYCLES(0), .IDLE_LEVEL(1'b0)) u_dut_z (
        .Clock (clk),
        .Reset (rst_n),
        .Start (start_z),
        .Data  (data),
        .Repeat(rpt),
        .Abort (abort),
        .Ready (ready_z),
        .Busy  (busy_z),
        .Signal(sig_z),
        .Done  (done_z)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_rec(input bit z, input rec_t r, input int keep);
        if (keep == 0 || push_n < keep) begin
            if (z) exp_z.push_back(r);
            else   exp_a.push_back(r);
        end
        push_n++;
    endtask

    // Expected per-cycle stream from the accept edge up to and including Done;
    // keep>0 truncates it to the first keep cycles (aborted transfer, no Done).
    task automatic push_model(input bit z, input logic [7:0] d, input int rep, input int gap,
                              input int keep, input int lat);
        rec_t r;
        push_n = 0;
        for (int k = 0; k <= rep; k++) begin
            for (int b = 7; b >= 0; b--) begin
                r.sig  = d[b];
                r.done = 1'b0;
                push_rec(z, r, keep);
            end
            if (k < rep) begin
                for (int g = 0; g < gap; g++) begin
                    r.sig  = 1'b0;
                    r.done = 1'b0;
                    push_rec(z, r, keep);
                end
            end
        end
        if (keep == 0) begin
            r.sig  = 1'b0;
            r.done = 1'b1;
            push_rec(z, r, keep);
            if (z) dcyc_z.push_back(cyc + lat);
            else   dcyc_a.push_back(cyc + lat);
        end
    endtask

    // Called at a negedge; returns at the negedge of cycle 1 after accept.
    task automatic start_xfer(input bit z, input logic [7:0] d, input int rep, input int gap,
                              input int keep, input int lat);
        push_model(z, d, rep, gap, keep, lat);
        data = d;
        rpt  = 4'(rep);
        if (z) start_z = 1'b1;
        else   start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start   = 1'b0;
        start_z = 1'b0;
    endtask

    task automatic wait_done(input bit z, input int limit);
        int i;
        i = 0;
        while (((z ? done_z : done) !== 1'b1) && i < limit) begin
            @(negedge clk);
            i++;
        end
        if ((z ? done_z : done) !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL done_timeout: got no Done after %0d cycles required Done=1", limit);
        end
    endtask

    always @(negedge clk) begin
        if (busy || done) begin
            if (exp_a.size() == 0) begin
                total++;
                bad++;
                $display("FAIL a_unexpected_output: got busy=%0b done=%0b required idle", busy, done);
            end else begin
                rec_a = exp_a.pop_front();
                chk("a_signal", 32'(sig), 32'(rec_a.sig));
                chk("a_done", 32'(done), 32'(rec_a.done));
                chk("a_ready", 32'(ready), 32'(rec_a.done));
                chk("a_busy", 32'(busy), 32'(!rec_a.done));
            end
            if (done) begin
                if (dcyc_a.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL a_spurious_done: got Done=1 required 0");
                end else begin
                    chk("a_done_cycle", 32'(cyc), 32'(dcyc_a.pop_front()));
                end
            end
        end else begin
            chk("a_idle_signal", 32'(sig), 32'd0);
            chk("a_idle_ready", 32'(ready), 32'd1);
        end
    end

    always @(negedge clk) begin
        if (busy_z || done_z) begin
            if (exp_z.size() == 0) begin
                total++;
                bad++;
                $display("FAIL z_unexpected_output: got busy=%0b done=%0b required idle",
                         busy_z, done_z);
            end else begin
                rec_z = exp_z.pop_front();
                chk("z_signal", 32'(sig_z), 32'(rec_z.sig));
                chk("z_done", 32'(done_z), 32'(rec_z.done));
                chk("z_busy", 32'(busy_z), 32'(!rec_z.done));
            end
            if (done_z) begin
                if (dcyc_z.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL z_spurious_done: got Done=1 required 0");
                end else begin
                    chk("z_done_cycle", 32'(cyc), 32'(dcyc_z.pop_front()));
                end
            end
        end else begin
            chk("z_idle_signal", 32'(sig_z), 32'd0);
        end
    end

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        start_z = 1'b0;
        abort   = 1'b0;
        data    = 8'h00;
        rpt     = 4'd0;
        repeat (2) @(negedge clk);
        chk("reset_ready", 32'(ready), 32'd1);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_signal", 32'(sig), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Single word, then a repeated word accepted in the Done cycle.
        start_xfer(1'b0, 8'hB2, 0, 2, 0, 9);
        wait_done(1'b0, 50);
        start_xfer(1'b0, 8'hB2, 2, 2, 0, 29);
        wait_done(1'b0, 100);
        @(negedge clk);

        // Contiguous copies on the zero-gap instance.
        start_xfer(1'b1, 8'hF0, 1, 0, 0, 17);
        wait_done(1'b1, 100);
        repeat (2) @(negedge clk);

        // Start while busy is ignored and not queued.
        start_xfer(1'b0, 8'h5C, 0, 2, 0, 9);
        repeat (2) @(negedge clk);
        data  = 8'h00;
        rpt   = 4'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(1'b0, 50);
        repeat (12) @(negedge clk);

        // Abort during cycle 4: four ones, then idle with no Done.
        start_xfer(1'b0, 8'hFF, 0, 2, 4, 0);
        repeat (3) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_ready", 32'(ready), 32'd1);
        repeat (4) @(negedge clk);
        start_xfer(1'b0, 8'h3C, 0, 2, 0, 9);
        wait_done(1'b0, 50);
        @(negedge clk);

        // Asynchronous reset between edges while shifting ones.
        start_xfer(1'b0, 8'hFF, 0, 2, 0, 9);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_signal", 32'(sig), 32'd0);
        chk("async_ready", 32'(ready), 32'd1);
        chk("async_busy", 32'(busy), 32'd0);
        exp_a.delete();
        dcyc_a.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Maximum repeat count: 16 words.
        start_xfer(1'b0, 8'hB2, 15, 2, 0, 159);
        wait_done(1'b0, 300);
        repeat (4) @(negedge clk);

        chk("a_stream_left", 32'(exp_a.size()), 32'd0);
        chk("a_done_left", 32'(dcyc_a.size()), 32'd0);
        chk("z_stream_left", 32'(exp_z.size()), 32'd0);
        chk("z_done_left", 32'(dcyc_z.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_pattern_tx.md
Name: serial_pattern_tx

Overview:
- Serial stimulus transmitter that drives the single-bit Signal line consumed by the team's Mealy sequence detectors.
- Accepts a WIDTH-bit word via a Start/Ready handshake and shifts it out MSB-first, one bit per Clock.
- Optionally repeats the word with an idle gap between copies.
- Replaces fixed stimulus generators in FSM benches with a programmable, synthesizable source.

Parameters:
WIDTH, 8, bits per word shifted out (≥2)
GAP_CYCLES, 2, idle cycles between repeated copies (0 = back-to-back)
IDLE_LEVEL, 0, value driven on Signal when not shifting data

Ports:
Clock  input  1  single system clock, rising-edge
Reset  input  1  asynchronous, active-low reset (0 = reset)
Start  input  1  request to send Data; sampled only when Ready=1
Data  input  WIDTH  word to transmit, captured on accept
Repeat  input  4  extra copies to send; total words = Repeat+1, captured on accept
Abort  input  1  synchronous cancel of an active transfer
Ready  output  1  1 = idle, able to accept Start
Busy  output  1  1 = transfer in progress (SHIFT or GAP)
Signal  output  1  serial data out
Done  output  1  one-cycle pulse on normal completion

Behaviour:
- All outputs registered; no combinational path from inputs to outputs.
- Reset=0 (async, any time, including mid-transfer):
  - State=IDLE; Ready=1, Busy=0, Done=0, Signal=IDLE_LEVEL.
  - Shift register, word copy, bit counter and repeat counter cleared.
- States:
  - IDLE: Ready=1, Signal=IDLE_LEVEL.
  - SHIFT: Signal=current bit.
  - GAP: Signal=IDLE_LEVEL.
- Accept: rising edge with Start=1 and Ready=1. On that edge:
  - Capture Data into the shift register and a word copy; capture Repeat into the repeat counter.
  - Go to SHIFT. Ready=0, Busy=1, Signal=Data[WIDTH-1], all visible in the cycle after the accept edge (latency 1).
- SHIFT: each edge shifts left; Signal takes the next bit. Bit counter runs 0..WIDTH-1 and holds each bit exactly one cycle.
- After the last bit (Data[0]):
  - Repeat counter ≠0 and GAP_CYCLES>0: go to GAP, decrement the counter.
  - Repeat counter ≠0 and GAP_CYCLES=0: reload the word copy, decrement the counter, stay in SHIFT. The next cycle drives the MSB with no idle bit between copies.
  - Repeat counter =0: go to IDLE. In that first IDLE cycle Done=1, Ready=1, Busy=0, Signal=IDLE_LEVEL.
- GAP: hold for exactly GAP_CYCLES cycles, then reload the word copy into the shift register and re-enter SHIFT driving the MSB.
- Done is exactly one cycle wide. Start=1 during the Done cycle is accepted (Ready=1), giving back-to-back transfers with one idle bit between them.
- Start while Ready=0 is ignored; it has no effect and is not queued. Data and Repeat changes after accept have no effect.
- Abort=1 at an edge while Busy=1:
  - Next cycle: IDLE, Ready=1, Busy=0, Signal=IDLE_LEVEL, Done=0 (no pulse).
  - Abort takes priority over shift, gap and completion on the same edge.
- Abort while idle has no effect. Abort and Start both 1 while idle: Start is accepted.
- Transfer duration from accept to Done cycle: (Repeat+1)·WIDTH + Repeat·GAP_CYCLES + 1 cycles.
- The repeat counter is 4 bits and never wraps: Repeat=15 sends exactly 16 words.

Test Plan:
- Reset, then Data=8'hB2, Repeat=0 → cycles 1..8 after accept Signal=1,0,1,1,0,0,1,0; cycle 9 Done=1, Ready=1; Signal=0 otherwise.
- Data=8'hB2, Repeat=2, GAP_CYCLES=2 → three copies of 10110010 separated by 00; Done at cycle 29; Busy=1 on cycles 1..28.
- Build with GAP_CYCLES=0: Data=8'hF0, Repeat=1 → Signal=1111000011110000 contiguous on cycles 1..16; Done at cycle 17.
- Start pulsed at cycle 3 of an active transfer with Data=8'h00 → ignored; original word completes unaltered; no second transfer.
- Abort at cycle 4 of Data=8'hFF → Signal=1 on cycles 1..4, then 0; Ready=1 at cycle 5; Done never asserted. A following Start sends a full new word.
- Reset driven to 0 asynchronously between clock edges mid-SHIFT → Signal=0, Ready=1, Busy=0 immediately, without waiting for an edge. After release, Repeat=15 with WIDTH=8, GAP=2 gives 16 words and Done at cycle 159.
